// File: rtl/vid_text_fetch.sv
// Text-row fetch engine: reads one 48-cell row from screen RAM (char and
// attribute per cell) through a 3-cycle-latency read port and presents the
// assembled cells on a valid/ready stream through a small FIFO.
module vid_text_fetch #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] row,
  output logic       busy,
  output logic       done,
  output logic [5:0] vp_x_0,
  output logic [4:0] vp_y_0,
  output logic       vp_sel_0,
  input  logic [7:0] vp_data_3,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [5:0] out_x,
  output logic [7:0] out_char,
  output logic [3:0] out_attr,
  output logic       out_last
);

  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW     = AW + 1;      // holds 0..FIFO_DEPTH
  localparam int SW     = AW + 2;      // holds fifo + in-flight sum
  localparam int STAGES = 2;           // tag pipe index of the returning read

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [5:0] LAST_COL = 6'd47;

  typedef struct packed {
    logic [5:0] x;
    logic [7:0] ch;
    logic [3:0] attr;
  } cell_t;

  logic [1:0]  state_q, state_d;
  logic [5:0]  col_q, col_d;
  logic        ph_q, ph_d;          // 0: char read next, 1: attr read next
  logic [4:0]  row_q, row_d;
  logic        done_q;

  logic [STAGES:0]      vld_pipe_q;
  logic [STAGES:0]      sel_pipe_q;
  logic [STAGES:0][5:0] x_pipe_q;

  logic [7:0]  hold_q;
  logic [CW-1:0] infl_q;            // cells whose char read is issued but not yet pushed

  cell_t [FIFO_DEPTH-1:0] mem_q;
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] fcnt_q;

  logic        iss_char, iss_attr, room, push, ret_char, pop;
  logic [SW-1:0] occ_sum;
  cell_t       head, wcell;

  // Space check: never commit a cell that the FIFO could not eventually hold.
  assign occ_sum = SW'(fcnt_q) + SW'(infl_q);
  assign room    = occ_sum < SW'(FIFO_DEPTH);

  assign ret_char = vld_pipe_q[STAGES] & ~sel_pipe_q[STAGES];
  assign push     = vld_pipe_q[STAGES] &  sel_pipe_q[STAGES];
  assign wcell    = '{x: x_pipe_q[STAGES], ch: hold_q, attr: vp_data_3[3:0]};

  assign head      = mem_q[rd_q];
  assign out_valid = fcnt_q != '0;
  assign out_x     = head.x;
  assign out_char  = head.ch;
  assign out_attr  = head.attr;
  assign out_last  = head.x == LAST_COL;
  assign pop       = out_valid & out_ready;

  assign busy   = state_q != S_IDLE;
  assign done   = done_q;
  assign vp_y_0 = (state_q == S_IDLE) ? 5'd0 : row_q;

  // Next-state and read-address generation; a stalled char slot holds the
  // address but is not tagged as an issue.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    ph_d     = ph_q;
    row_d    = row_q;
    vp_x_0   = '0;
    vp_sel_0 = 1'b0;
    iss_char = 1'b0;
    iss_attr = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && row <= 5'd27) begin
          state_d = S_FETCH;
          row_d   = row;
          col_d   = '0;
          ph_d    = 1'b0;
        end
      end
      S_FETCH: begin
        vp_x_0   = col_q;
        vp_sel_0 = ph_q;
        if (!ph_q) begin
          if (room) begin
            iss_char = 1'b1;
            ph_d     = 1'b1;
          end
        end else begin
          iss_attr = 1'b1;
          ph_d     = 1'b0;
          if (col_q == LAST_COL) state_d = S_DRAIN;
          else                   col_d   = col_q + 6'd1;
        end
      end
      S_DRAIN: begin
        if (pop && out_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, done pulse after the final cell is handed off.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      ph_q    <= 1'b0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      ph_q    <= ph_d;
      row_q   <= row_d;
      done_q  <= (state_q == S_DRAIN) && pop && out_last;
    end
  end

  // Read tag pipeline aligned with RAM latency; clearing it on reset drops
  // any data still returning from an aborted row.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      sel_pipe_q <= '0;
      x_pipe_q   <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[STAGES-1:0], iss_char | iss_attr};
      sel_pipe_q <= {sel_pipe_q[STAGES-1:0], iss_attr};
      x_pipe_q   <= {x_pipe_q[STAGES-1:0], col_q};
    end
  end

  // Char holding register and in-flight cell count.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      infl_q <= '0;
    end else begin
      if (ret_char) hold_q <= vp_data_3;
      infl_q <= infl_q + CW'(iss_char) - CW'(push);
    end
  end

  // Cell FIFO; simultaneous push and pop is legal at any fill level.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= wcell;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
      fcnt_q <= fcnt_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_vid_text_fetch.sv
// Directed bench for vid_text_fetch with a 3-cycle screen RAM model.
module tb_vid_text_fetch;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, start, out_ready;
  logic [4:0] row;
  logic       busy, done, vp_sel_0, out_valid, out_last;
  logic [5:0] vp_x_0, out_x;
  logic [4:0] vp_y_0;
  logic [7:0] vp_data_3, out_char;
  logic [3:0] out_attr;

  vid_text_fetch #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .row(row), .busy(busy), .done(done),
    .vp_x_0(vp_x_0), .vp_y_0(vp_y_0), .vp_sel_0(vp_sel_0), .vp_data_3(vp_data_3),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .out_char(out_char), .out_attr(out_attr), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mchar(input int x, input int y);
    return 8'(x + y * 3);
  endfunction
  function automatic logic [3:0] mattr(input int x, input int y);
    return 4'(x ^ y);
  endfunction

  // screen RAM: address seen in cycle c answers in cycle c+3
  typedef struct packed { logic [5:0] x; logic [4:0] y; logic sel; } ra_t;
  ra_t rp0, rp1, rp2;
  always @(posedge clk) begin
    rp0 <= {vp_x_0, vp_y_0, vp_sel_0};
    rp1 <= rp0;
    rp2 <= rp1;
  end
  assign vp_data_3 = rp2.sel ? {4'h0, mattr(int'(rp2.x), int'(rp2.y))}
                             : mchar(int'(rp2.x), int'(rp2.y));

  int nchk = 0, nerr = 0;
  task automatic chk(input string tag, input int got, input int want);
    nchk++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  int rel, mode, exp_x, exp_row, ncell, ndone, first_v, done_cyc, last_cyc;
  int attr_iss, pops, max_out, y_err, busy_at_done, iss60, valid60, nbusy, nx, nvalid;
  bit aborted, inj_done;

  function automatic logic rdy(input int r);
    case (mode)
      0: return 1'b1;
      1: return r > 60;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic clear_mon();
    exp_x = 0; ncell = 0; ndone = 0; first_v = -1; done_cyc = -1; last_cyc = -1;
    attr_iss = 0; pops = 0; max_out = 0; y_err = 0; busy_at_done = -1;
    iss60 = -1; valid60 = -1; nbusy = 0; nx = 0; nvalid = 0;
  endtask

  task automatic sample();
    if (out_valid && first_v < 0) first_v = rel;
    if (out_valid) nvalid++;
    if (busy) nbusy++;
    if (vp_x_0 != 0) nx++;
    if (vp_sel_0) attr_iss++;
    if (busy && vp_y_0 != 5'(exp_row)) y_err++;
    if (out_valid && out_ready) begin
      chk("cell_x", int'(out_x), exp_x);
      chk("cell_char", int'(out_char), int'(mchar(exp_x, exp_row)));
      chk("cell_attr", int'(out_attr), int'(mattr(exp_x, exp_row)));
      chk("cell_last", int'(out_last), int'(exp_x == 47));
      if (out_x == 6'd47) last_cyc = rel;
      exp_x++; ncell++; pops++;
    end
    if (attr_iss - pops > max_out) max_out = attr_iss - pops;
    if (rel == 60) begin iss60 = attr_iss; valid60 = int'(out_valid); end
    if (done) begin ndone++; done_cyc = rel; busy_at_done = int'(busy); end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    rel++;
    out_ready = rdy(rel);
  endtask

  task automatic run_row(input int r, input int m, input int inj_x, input int abort_x);
    clear_mon();
    mode = m; exp_row = r; rel = 0; aborted = 0; inj_done = 0;
    start = 1'b1; row = 5'(r); out_ready = rdy(0);
    tick();
    start = 1'b0;
    while (ndone == 0 && rel < 600 && !aborted) begin
      if (inj_x >= 0 && !inj_done && busy && vp_x_0 == 6'(inj_x)) begin
        start = 1'b1; row = 5'd3; inj_done = 1;
        tick();
        start = 1'b0;
      end else if (abort_x >= 0 && busy && vp_x_0 == 6'(abort_x) && !vp_sel_0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        aborted = 1;
      end else begin
        tick();
      end
    end
    if (!aborted) begin
      repeat (5) tick();
      chk("cells", ncell, 48);
      chk("dones", ndone, 1);
      chk("y_hold", y_err, 0);
      chk("max_outstanding_le", int'(max_out <= DEPTH), 1);
      chk("busy_at_done", busy_at_done, 0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; row = '0; out_ready = 1'b1; mode = 0;
    clear_mon();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_out_x", int'(out_x), 0);
    chk("rst_out_char", int'(out_char), 0);
    chk("rst_out_attr", int'(out_attr), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_vp_x", int'(vp_x_0), 0);
    chk("rst_vp_y", int'(vp_y_0), 0);
    chk("rst_vp_sel", int'(vp_sel_0), 0);
    rst = 1'b0;

    // streaming row, consumer always ready
    run_row(5, 0, -1, -1);
    chk("first_valid_cyc", first_v, 6);
    chk("last_cell_cyc", last_cyc, 100);
    chk("done_cyc", done_cyc, 101);

    // consumer stalled through cycle 60
    run_row(5, 1, -1, -1);
    chk("stall_attr_issues", iss60, 4);
    chk("stall_valid60", valid60, 1);
    chk("stall_max_outstanding", max_out, DEPTH);

    // random backpressure on the boundary rows
    run_row(0, 2, -1, -1);
    run_row(27, 2, -1, -1);

    // out-of-range row is ignored
    clear_mon(); mode = 0; rel = 0;
    start = 1'b1; row = 5'd28;
    tick();
    start = 1'b0;
    repeat (10) tick();
    chk("row28_busy", nbusy, 0);
    chk("row28_attr_reads", attr_iss, 0);
    chk("row28_addr", nx, 0);

    // start while busy at column 10 is ignored
    run_row(5, 0, 10, -1);
    chk("inj_first_valid", first_v, 6);
    chk("inj_done_cyc", done_cyc, 101);

    // reset mid-row at column 20
    run_row(12, 0, -1, 20);
    chk("abort_taken", int'(aborted), 1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(out_valid), 0);
    chk("abort_out_x", int'(out_x), 0);
    chk("abort_out_char", int'(out_char), 0);
    chk("abort_vp_x", int'(vp_x_0), 0);
    chk("abort_vp_y", int'(vp_y_0), 0);
    chk("abort_vp_sel", int'(vp_sel_0), 0);
    clear_mon(); mode = 0;
    repeat (10) tick();
    chk("abort_idle_valid", nvalid, 0);
    run_row(9, 0, -1, -1);
    chk("after_abort_first_valid", first_v, 6);
    chk("after_abort_done_cyc", done_cyc, 101);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
